alu_operand_loader: RTL and testbench

- Upstream stage for the 4-bit mini ALU.
- Turns raw board keys into a stable operand set: a 4-bit nibble is entered on level switches and committed by a debounced ENTER button, in the order A, then B, then op.
- The complete {A, B, op} set is then offered to the ALU over a valid/ready handshake.
- A debounced CLEAR button aborts entry at any point.

---
 rtl/alu_operand_loader_if.sv | 25 ++
 rtl/alu_operand_loader.sv | 146 ++++++++++++++
 tb/tb_alu_operand_loader.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_loader_if.sv
// Operand set handshake between the key loader and the 4-bit mini ALU.
// The loader drives the master side; the ALU drives ready on the slave side.
interface alu_operand_loader_if;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic       valid;
    logic       ready;

    modport master (
        output a,
        output b,
        output op,
        output valid,
        input  ready
    );

    modport slave (
        input  a,
        input  b,
        input  op,
        input  valid,
        output ready
    );
endinterface

// File: rtl/alu_operand_loader.sv
// Key-driven operand entry for the mini ALU: debounced ENTER/CLEAR buttons
// commit A, B and op in turn, then offer the set over valid/ready.
module alu_operand_loader_debounce #(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    localparam int unsigned CW = $clog2(CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // The level flips on the CYCLES-th consecutive mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            pulse   <= level & ~level_d;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module alu_operand_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           key,
    alu_operand_loader_if.master bus,
    output logic [1:0]           state,
    output logic                 enter_pulse
);
    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        ISSUE   = 2'd3
    } state_t;

    state_t     st;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [1:0] op_q;
    logic       valid_q;
    logic       enter_p;
    logic       clear_p;
    logic       unused_keys;

    assign unused_keys = ^key[7:6];

    alu_operand_loader_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_enter (
        .clk   (clock),
        .rst_n (reset),
        .btn   (key[4]),
        .pulse (enter_p)
    );

    alu_operand_loader_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_clear (
        .clk   (clock),
        .rst_n (reset),
        .btn   (key[5]),
        .pulse (clear_p)
    );

    // CLEAR outranks everything, including a coincident ENTER.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st      <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else if (clear_p) begin
            st      <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (st)
                LOAD_A: begin
                    if (enter_p) begin
                        a_q <= key[3:0];
                        st  <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (enter_p) begin
                        b_q <= key[3:0];
                        st  <= LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (enter_p) begin
                        op_q    <= key[1:0];
                        valid_q <= 1'b1;
                        st      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (valid_q && bus.ready) begin
                        valid_q <= 1'b0;
                        st      <= LOAD_A;
                    end
                end
                default: begin
                    st      <= LOAD_A;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a       = a_q;
    assign bus.b       = b_q;
    assign bus.op      = op_q;
    assign bus.valid   = valid_q;
    assign state       = st;
    assign enter_pulse = enter_p;
endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: scenario tasks plus a transfer scoreboard
// that checks every accepted operand set against the queued expectation.
module tb_alu_operand_loader;
    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] key = '0;
    logic [1:0] state;
    logic       enter_pulse;

    int vectors = 0;
    int miscompares = 0;
    logic [9:0] exp_q[$];

    alu_operand_loader_if bus();

    alu_operand_loader #(
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock       (clk),
        .reset       (rst_n),
        .key         (key),
        .bus         (bus.master),
        .state       (state),
        .enter_pulse (enter_pulse)
    );

    always #5 clk = ~clk;

    // Scoreboard: every handshake pops and compares one expected set.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL xfer_unexpected got=%h required=none",
                             {bus.a, bus.b, bus.op});
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.a, bus.b, bus.op} !== e) begin
                        miscompares++;
                        $display("FAIL xfer_data got=%h required=%h",
                                 {bus.a, bus.b, bus.op}, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] m);
        key = key | m;
        repeat (12) tick();
        key = key & ~m;
        repeat (10) tick();
    endtask

    task automatic enter_nibble(input logic [3:0] n);
        key[3:0] = n;
        press(8'h10);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key = '0;
        bus.ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drain();
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if (state !== 2'd0) begin
            miscompares++;
            $display("FAIL rst_state got=%0d required=0", state);
        end
        vectors++;
        if (bus.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_valid got=%b required=0", bus.valid);
        end
        vectors++;
        if ({bus.a, bus.b, bus.op} !== 10'h0) begin
            miscompares++;
            $display("FAIL rst_abop got=%h required=0",
                     {bus.a, bus.b, bus.op});
        end
        vectors++;
        if (enter_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_pulse got=%b required=0", enter_pulse);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_enter_latency();
        int first;
        int np;
        int rel;
        first = 0;
        np = 0;
        rel = 0;
        key[3:0] = 4'h5;
        key[4] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (enter_pulse === 1'b1) begin
                np++;
                if (first == 0) first = i;
            end
            if (i == 8) begin
                vectors++;
                if (bus.a !== 4'h5 || state !== 2'd1) begin
                    miscompares++;
                    $display("FAIL lat_commit got=%h/%0d required=5/1",
                             bus.a, state);
                end
            end
        end
        vectors++;
        if (first != DEB + 3) begin
            miscompares++;
            $display("FAIL lat_edge got=%0d required=%0d", first, DEB + 3);
        end
        vectors++;
        if (np != 1) begin
            miscompares++;
            $display("FAIL lat_single got=%0d required=1", np);
        end
        key[4] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (enter_pulse === 1'b1) rel++;
        end
        vectors++;
        if (rel != 0 || state !== 2'd1) begin
            miscompares++;
            $display("FAIL release got=%0d/%0d required=0/1", rel, state);
        end
    endtask

    task automatic test_full_entry();
        int bad;
        logic [9:0] e;
        bad = 0;
        e = {4'h3, 4'h9, 2'b01};
        do_reset();
        enter_nibble(4'h3);
        enter_nibble(4'h9);
        enter_nibble(4'h1);
        exp_q.push_back(e);
        vectors++;
        if (bus.valid !== 1'b1 || state !== 2'd3) begin
            miscompares++;
            $display("FAIL issue got=%b/%0d required=1/3", bus.valid, state);
        end
        vectors++;
        if ({bus.a, bus.b, bus.op} !== e) begin
            miscompares++;
            $display("FAIL operands got=%h required=%h",
                     {bus.a, bus.b, bus.op}, e);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.valid !== 1'b1 || {bus.a, bus.b, bus.op} !== e) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL hold got=%0d required=0", bad);
        end
        drain();
        vectors++;
        if (bus.valid !== 1'b0 || state !== 2'd0) begin
            miscompares++;
            $display("FAIL post_xfer got=%b/%0d required=0/0",
                     bus.valid, state);
        end
        vectors++;
        if ({bus.a, bus.b, bus.op} !== e || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL keep got=%h/%0d required=%h/0",
                     {bus.a, bus.b, bus.op}, exp_q.size(), e);
        end
    endtask

    task automatic test_glitch();
        int np;
        np = 0;
        key[4] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (enter_pulse === 1'b1) np++;
        end
        key[4] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (enter_pulse === 1'b1) np++;
        end
        vectors++;
        if (np != 0 || state !== 2'd0) begin
            miscompares++;
            $display("FAIL glitch got=%0d/%0d required=0/0", np, state);
        end
    endtask

    task automatic test_clear_priority();
        logic [9:0] e;
        enter_nibble(4'hA);
        enter_nibble(4'hC);
        vectors++;
        if (state !== 2'd2) begin
            miscompares++;
            $display("FAIL load_op got=%0d required=2", state);
        end
        key[3:0] = 4'h2;
        press(8'h30);
        vectors++;
        if (state !== 2'd0 || bus.valid !== 1'b0 ||
            {bus.a, bus.b, bus.op} !== 10'h0) begin
            miscompares++;
            $display("FAIL clear got=%0d/%b/%h required=0/0/0",
                     state, bus.valid, {bus.a, bus.b, bus.op});
        end
        e = {4'h7, 4'h2, 2'b11};
        enter_nibble(4'h7);
        enter_nibble(4'h2);
        enter_nibble(4'h3);
        exp_q.push_back(e);
        key[3:0] = 4'hE;
        press(8'h10);
        press(8'h10);
        vectors++;
        if (state !== 2'd3 || bus.valid !== 1'b1 ||
            {bus.a, bus.b, bus.op} !== e) begin
            miscompares++;
            $display("FAIL issue_enter got=%0d/%b/%h required=3/1/%h",
                     state, bus.valid, {bus.a, bus.b, bus.op}, e);
        end
        drain();
    endtask

    task automatic test_async_reset();
        logic [9:0] e;
        enter_nibble(4'h6);
        enter_nibble(4'h6);
        enter_nibble(4'h2);
        vectors++;
        if (bus.valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_areset got=%b required=1", bus.valid);
        end
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.valid !== 1'b0 || state !== 2'd0 ||
            {bus.a, bus.b, bus.op} !== 10'h0) begin
            miscompares++;
            $display("FAIL areset got=%b/%0d/%h required=0/0/0",
                     bus.valid, state, {bus.a, bus.b, bus.op});
        end
        #2;
        rst_n = 1'b1;
        tick();
        e = {4'hF, 4'h1, 2'b00};
        enter_nibble(4'hF);
        enter_nibble(4'h1);
        enter_nibble(4'h0);
        exp_q.push_back(e);
        vectors++;
        if (bus.valid !== 1'b1 || {bus.a, bus.b, bus.op} !== e) begin
            miscompares++;
            $display("FAIL re_entry got=%b/%h required=1/%h",
                     bus.valid, {bus.a, bus.b, bus.op}, e);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        bus.ready = 1'b1;
        enter_nibble(4'h4);
        enter_nibble(4'h5);
        exp_q.push_back({4'h4, 4'h5, 2'b10});
        enter_nibble(4'h2);
        vectors++;
        if (bus.valid !== 1'b0 || state !== 2'd0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL one_cycle got=%b/%0d/%0d required=0/0/0",
                     bus.valid, state, exp_q.size());
        end
        bus.ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_enter_latency();
        test_full_entry();
        test_glitch();
        test_clear_priority();
        test_async_reset();
        test_back_to_back();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover got=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
